modulator_frame_scheduler: RTL and testbench
============================================

# modulator_frame_scheduler

Frame sequencer in front of the modulator FIFO. It interleaves 32-bit sync words and 40-bit payload words from two AXI-stream sources into one 40-bit stream. Each sync word is tagged `tstrb=5'h01` and each payload word `tstrb=5'h00`, in the order one sync word, then `cfg_words` payload words. It aborts a starved frame and pulses `reset_mod` so the modulator realigns to subcarrier 0.

## Interface
- `SYNC_WIDTH`, 32, sync word width.
- `DATA_WIDTH`, 40, payload and output word width.
- `CNT_WIDTH`, 8, width of the payload word counter and of `cfg_words`.
- `STARVE_CYCLES`, 1024, consecutive payload-idle cycles in PAYLOAD before abort.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new frames to start.
- `cfg_words`  in  CNT_WIDTH  payload words per frame; sampled at the sync word accept; 0 is treated as 1.
- `sync_valid` / `sync_ready`  in / out  1  sync source handshake.
- `sync_data`  in  SYNC_WIDTH  sync word.
- `pay_valid` / `pay_ready`  in / out  1  payload source handshake.
- `pay_data`  in  DATA_WIDTH  payload word.
- `m_valid` / `m_ready`  out / in  1  modulator FIFO handshake.
- `m_data`  out  DATA_WIDTH  word to the modulator; sync words are zero-extended.
- `m_tstrb`  out  DATA_WIDTH/8  5'h01 for a sync word, 5'h00 for a payload word.
- `reset_mod`  out  1  one-cycle abort pulse.
- `frame_cnt`  out  16  completed frames; wraps at 16 bits.
- `st`  out  2  current state.

## Operation
- States: IDLE=0, SYNC=1, PAYLOAD=2, ABORT=3.
- Output register `load = !m_valid || m_ready`.
- IDLE:
  - `enable && sync_valid` -> SYNC next cycle.
  - Neither source is ready in IDLE.
- SYNC:
  - `sync_ready = load`.
  - On accept: register `{8'h00, sync_data}` with tstrb 5'h01.
  - Latch `words = max(cfg_words, 1)`, clear `word_cnt` and the starve counter, go to PAYLOAD.
- PAYLOAD:
  - `pay_ready = load`.
  - On accept: register `pay_data` with tstrb 5'h00, `word_cnt++`, clear the starve counter.
  - On the accept where `word_cnt == words-1`: increment `frame_cnt`.
    - Then go to SYNC if `enable && sync_valid`, else IDLE.
- Starvation, checked in PAYLOAD only:
  - The starve counter increments on each cycle with `!pay_valid`.
  - A cycle with `pay_valid && !load` (downstream backpressure) does not increment it.
  - When the counter reaches `STARVE_CYCLES-1`, go to ABORT.
- ABORT (one cycle):
  - `reset_mod=1`, `m_valid` cleared (a pending word is dropped), counters cleared, `frame_cnt` unchanged.
  - Then IDLE.
- `enable` deasserted mid-frame: the current frame completes; no new frame starts.
- `sync_valid` while in PAYLOAD: ignored (`sync_ready=0`).
- `pay_valid` while in IDLE or SYNC: ignored.
- Reset mid-frame:
  - Next cycle: IDLE, `m_valid=0`, counters 0.
  - No `reset_mod` pulse; the modulator is reset by the same `rst`.

## Timing
- Reset values:
  - `m_valid=0`, `m_data=0`, `m_tstrb=0`.
  - `sync_ready=0`, `pay_ready=0`, `reset_mod=0`.
  - `frame_cnt=0`, `st=0`.
- Latency: an upstream accept at edge N gives `m_valid=1` with that word from edge N onward. This is one register stage.
- `m_data`, `m_valid` and `m_tstrb` are held stable while `m_valid && !m_ready`.
- `sync_ready` and `pay_ready` are combinational from `state`, `m_valid` and `m_ready`; there is no combinational path from `*_valid` to `*_ready`.
- Full throughput: one word per cycle with `m_ready=1`.
- Frame of `cfg_words=W` with no stalls: W+1 consecutive output beats.
- IDLE -> SYNC costs one bubble.
- The frame-to-frame direct transition PAYLOAD -> SYNC costs no bubble in PAYLOAD; SYNC accepts on the next cycle.
- Abort: `reset_mod` is high exactly one cycle, STARVE_CYCLES cycles after the last payload accept.

## Structure
- Shared package `modulator_pkg`:
  - state enum (IDLE/SYNC/PAYLOAD/ABORT);
  - `TSTRB_SYNC=5'h01`, `TSTRB_DATA=5'h00`;
  - default widths.
- One natural sub-module, `axis_out_reg`: output register with hold-under-backpressure and a synchronous flush input (driven in ABORT).

## Test plan
- `cfg_words=3`, `m_ready=1`, sync 32'hA5A5A5A5, payload 40'h01..40'h03 -> beats {A5A5A5A5, tstrb 01}, {01, 00}, {02, 00}, {03, 00}; `frame_cnt` 0->1.
- Same frame with `m_ready` toggling 1010…:
  - no duplicated or lost beats;
  - `m_data` stable on every stalled cycle;
  - ready low whenever `m_valid && !m_ready`.
- `cfg_words=0` -> exactly one payload beat per frame; three back-to-back frames give 6 beats with no idle cycle between frames, `frame_cnt=3`.
- `STARVE_CYCLES=16`, `pay_valid` dropped after 1 of 4 words:
  - `reset_mod` pulses 16 cycles after that accept;
  - `m_valid` drops;
  - `st` goes 3 then 0;
  - `frame_cnt` unchanged.
- `enable` deasserted during word 2 of 4 -> frame completes; the next `sync_valid` is not accepted; `st` stays 0.
- `rst` asserted while `m_valid=1` mid-frame -> next cycle all outputs at reset values; a new frame after reset starts with a sync beat.

Source files
------------

// File: rtl/modulator_pkg.sv
// modulator_pkg: shared states, tstrb tags and default widths for the modulator frame path
package modulator_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, PAYLOAD = 2'd2, ABORT = 2'd3} state_t;
    localparam logic [4:0] TSTRB_SYNC = 5'h01;
    localparam logic [4:0] TSTRB_DATA = 5'h00;
    localparam int SYNC_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 40;
    localparam int CNT_WIDTH_DEF = 8;
    localparam int STARVE_CYCLES_DEF = 1024;
endpackage

// File: rtl/modulator_frame_scheduler_axis_out_reg.sv
// axis_out_reg: single-stage AXI-stream output register with hold under backpressure and flush
module axis_out_reg #(
    parameter int DATA_WIDTH = 40,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [STRB_WIDTH-1:0] in_tstrb,
    input  logic                  m_ready,
    output logic                  load,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [STRB_WIDTH-1:0] m_tstrb
);
    always_comb load = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_tstrb <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_tstrb <= in_tstrb;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/modulator_frame_scheduler.sv
// modulator_frame_scheduler: interleaves sync and payload words into one tagged stream, aborting starved frames
module modulator_frame_scheduler
    import modulator_pkg::*;
#(
    parameter int SYNC_WIDTH    = SYNC_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int STARVE_CYCLES = STARVE_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [CNT_WIDTH-1:0]    cfg_words,
    input  logic                    sync_valid,
    output logic                    sync_ready,
    input  logic [SYNC_WIDTH-1:0]   sync_data,
    input  logic                    pay_valid,
    output logic                    pay_ready,
    input  logic [DATA_WIDTH-1:0]   pay_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic                    reset_mod,
    output logic [15:0]             frame_cnt,
    output logic [1:0]              st
);
    localparam int SCW = $clog2(STARVE_CYCLES);

    state_t               state;
    logic                 load, sync_acc, pay_acc, last, starved;
    logic [CNT_WIDTH-1:0] words, word_cnt;
    logic [SCW-1:0]       starve;

    always_comb begin
        sync_ready = state == SYNC && load;
        pay_ready  = state == PAYLOAD && load;
        sync_acc   = sync_ready && sync_valid;
        pay_acc    = pay_ready && pay_valid;
        last       = pay_acc && word_cnt == words - CNT_WIDTH'(1);
        starved    = state == PAYLOAD && !pay_valid && starve == SCW'(STARVE_CYCLES - 1);
        st         = state;
    end

    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk      (clk),
        .rst      (rst),
        .flush    (starved),
        .in_valid (sync_acc || pay_acc),
        .in_data  (sync_acc ? {{(DATA_WIDTH - SYNC_WIDTH){1'b0}}, sync_data} : pay_data),
        .in_tstrb (sync_acc ? TSTRB_SYNC : TSTRB_DATA),
        .m_ready  (m_ready),
        .load     (load),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_tstrb  (m_tstrb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            words     <= '0;
            word_cnt  <= '0;
            starve    <= '0;
            reset_mod <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (enable && sync_valid) state <= SYNC;
                SYNC: if (sync_acc) begin
                    words    <= cfg_words == '0 ? CNT_WIDTH'(1) : cfg_words;
                    word_cnt <= '0;
                    starve   <= '0;
                    state    <= PAYLOAD;
                end
                PAYLOAD: if (pay_acc) begin
                    word_cnt <= word_cnt + CNT_WIDTH'(1);
                    starve   <= '0;
                    if (last) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= enable && sync_valid ? SYNC : IDLE;
                    end
                end else if (starved) begin
                    state     <= ABORT;
                    reset_mod <= 1'b1;
                end else if (!pay_valid) begin
                    starve <= starve + SCW'(1);
                end
                ABORT: begin
                    state     <= IDLE;
                    reset_mod <= 1'b0;
                    words     <= '0;
                    word_cnt  <= '0;
                    starve    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_modulator_frame_scheduler.sv
// tb_modulator_frame_scheduler: randomized and directed checks against a frame-level reference model
module tb_modulator_frame_scheduler;
    localparam int SW = 32, DW = 40, CW = 8, SC = 16, TW = DW / 8;

    logic clk = 1'b0;
    logic rst, enable, sync_valid, pay_valid, m_ready;
    logic [CW-1:0] cfg_words;
    logic [SW-1:0] sync_data;
    logic [DW-1:0] pay_data;
    logic sync_ready, pay_ready, m_valid, reset_mod;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tstrb;
    logic [15:0] frame_cnt;
    logic [1:0] st;

    int checks = 0, failures = 0, cyc = 0;
    int sv_p = 100, pv_p = 100, mr_p = 100;
    logic [SW-1:0] sq[$];
    logic [DW-1:0] pq[$];
    logic [DW+TW-1:0] beats[$];
    int beat_cyc[$];

    int ph, left, quiet, e_fc;
    bit e_v, e_rm, last_sa, last_pa;
    logic [DW-1:0] e_d;
    logic [TW-1:0] e_t;

    always #5 clk = ~clk;

    modulator_frame_scheduler #(.SYNC_WIDTH(SW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STARVE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_words(cfg_words),
        .sync_valid(sync_valid), .sync_ready(sync_ready), .sync_data(sync_data),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tstrb(m_tstrb),
        .reset_mod(reset_mod), .frame_cnt(frame_cnt), .st(st)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
        end
    endtask

    // ph: 0 waiting for a frame, 1 sync owed, 2 payload owed (left words), 3 abort
    task automatic model_step();
        bit ld;
        last_sa = 0;
        last_pa = 0;
        if (rst) begin
            ph = 0; left = 0; quiet = 0; e_fc = 0; e_v = 0; e_rm = 0; e_d = '0; e_t = '0;
            return;
        end
        ld = !e_v || m_ready;
        last_sa = ph == 1 && ld && sync_valid;
        last_pa = ph == 2 && ld && pay_valid;
        e_rm = 0;
        if (e_v && m_ready) e_v = 0;
        if (ph == 3) begin
            ph = 0;
        end else if (last_sa) begin
            e_v = 1; e_d = {8'h00, sync_data}; e_t = 5'h01;
            left = cfg_words == 0 ? 1 : int'(cfg_words);
            quiet = 0;
            ph = 2;
        end else if (last_pa) begin
            e_v = 1; e_d = pay_data; e_t = 5'h00;
            quiet = 0;
            left--;
            if (left == 0) begin
                e_fc = (e_fc + 1) % 65536;
                ph = enable && sync_valid ? 1 : 0;
            end
        end else if (ph == 2 && !pay_valid) begin
            quiet++;
            if (quiet == SC) begin
                ph = 3; e_rm = 1; e_v = 0;
            end
        end else if (ph == 0 && enable && sync_valid) begin
            ph = 1;
        end
    endtask

    task automatic compare();
        bit ld;
        ld = !e_v || m_ready;
        chk("m_valid", m_valid, e_v);
        if (e_v) begin
            chk("m_data", m_data, e_d);
            chk("m_tstrb", m_tstrb, e_t);
        end
        chk("sync_ready", sync_ready, ph == 1 && ld);
        chk("pay_ready", pay_ready, ph == 2 && ld);
        chk("reset_mod", reset_mod, e_rm);
        chk("frame_cnt", frame_cnt, e_fc);
        chk("st", st, ph);
    endtask

    task automatic tick();
        sync_valid = sq.size() > 0 && int'($urandom_range(99)) < sv_p;
        sync_data  = sq.size() > 0 ? sq[0] : '0;
        pay_valid  = pq.size() > 0 && int'($urandom_range(99)) < pv_p;
        pay_data   = pq.size() > 0 ? pq[0] : '0;
        m_ready    = mr_p < 0 ? (cyc % 2 == 0) : (int'($urandom_range(99)) < mr_p);
        #1;
        compare();
        if (m_valid && m_ready) begin
            beats.push_back({m_tstrb, m_data});
            beat_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        if (last_sa) void'(sq.pop_front());
        if (last_pa) void'(pq.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beats.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("beat_budget", beats.size() >= n, 1);
    endtask

    task automatic check_frame3(input string tag);
        chk({tag, "_n"}, beats.size(), 4);
        if (beats.size() == 4) begin
            chk({tag, "_b0"}, beats[0], {5'h01, 40'h00A5A5A5A5});
            chk({tag, "_b1"}, beats[1], {5'h00, 40'h01});
            chk({tag, "_b2"}, beats[2], {5'h00, 40'h02});
            chk({tag, "_b3"}, beats[3], {5'h00, 40'h03});
        end
    endtask

    initial begin
        int acc_c, rm_c, k;
        rst = 1; enable = 0; cfg_words = '0; sync_valid = 0; sync_data = '0;
        pay_valid = 0; pay_data = '0; m_ready = 0;
        @(negedge clk);
        @(posedge clk);
        model_step();
        @(negedge clk);
        tick();
        chk("rst_m_data", m_data, 0);
        chk("rst_m_tstrb", m_tstrb, 0);
        chk("rst_st", st, 0);
        rst = 0;
        enable = 1;

        cfg_words = 3;
        sq.push_back(32'hA5A5A5A5);
        for (int i = 1; i <= 3; i++) pq.push_back(DW'(i));
        beats.delete();
        run_beats(4, 30);
        check_frame3("basic");
        tick();
        chk("basic_fc", frame_cnt, 1);

        mr_p = -1;
        sq.push_back(32'hA5A5A5A5);
        for (int i = 1; i <= 3; i++) pq.push_back(DW'(i));
        beats.delete();
        run_beats(4, 40);
        check_frame3("stall");
        mr_p = 100;
        tick();
        chk("stall_fc", frame_cnt, 2);

        cfg_words = 0;
        sq = '{32'h11, 32'h22, 32'h33};
        pq = '{40'hA, 40'hB, 40'hC};
        beats.delete();
        beat_cyc.delete();
        run_beats(6, 30);
        chk("b2b_n", beats.size(), 6);
        if (beats.size() == 6) begin
            chk("b2b_span", beat_cyc[5] - beat_cyc[0], 5);
            for (int i = 0; i < 6; i++) chk("b2b_tag", beats[i][DW+TW-1:DW], i % 2 == 0 ? 1 : 0);
            chk("b2b_b4", beats[4], {5'h01, 40'h33});
        end
        tick();
        chk("b2b_fc", frame_cnt, 5);

        cfg_words = 4;
        sq.push_back(32'h77);
        pq.push_back(40'h100);
        acc_c = -1000;
        rm_c = -1;
        k = 0;
        while (rm_c < 0 && k < 60) begin
            tick();
            k++;
            if (last_pa) acc_c = cyc;
            if (reset_mod) rm_c = cyc;
        end
        chk("abort_delay", rm_c - acc_c, SC);
        chk("abort_st", st, 3);
        chk("abort_mv", m_valid, 0);
        tick();
        chk("abort_idle", st, 0);
        chk("abort_rm_off", reset_mod, 0);
        chk("abort_fc", frame_cnt, 5);

        sq = '{32'h88, 32'h99};
        pq = '{40'h1, 40'h2, 40'h3, 40'h4};
        k = 0;
        while (pq.size() > 0 && k < 40) begin
            tick();
            k++;
            if (pq.size() == 3) enable = 0;
        end
        for (int i = 0; i < 6; i++) tick();
        chk("en_fc", frame_cnt, 6);
        chk("en_sq_left", sq.size(), 1);
        chk("en_st", st, 0);
        sq.delete();
        enable = 1;

        sq.push_back(32'hAA);
        for (int i = 1; i <= 4; i++) pq.push_back(DW'(i));
        mr_p = 0;
        k = 0;
        while (!m_valid && k < 20) begin
            tick();
            k++;
        end
        chk("mid_mv", m_valid, 1);
        rst = 1;
        tick();
        rst = 0;
        sq.delete();
        pq.delete();
        chk("rst_mv", m_valid, 0);
        chk("rst_st2", st, 0);
        chk("rst_fc", frame_cnt, 0);
        chk("rst_rm", reset_mod, 0);
        chk("rst_md", m_data, 0);
        chk("rst_sr", sync_ready, 0);
        mr_p = 100;
        cfg_words = 1;
        sq.push_back(32'hBB);
        pq.push_back(40'h5);
        beats.delete();
        run_beats(2, 20);
        if (beats.size() >= 2) begin
            chk("post_rst_b0", beats[0], {5'h01, 40'hBB});
            chk("post_rst_b1", beats[1], {5'h00, 40'h5});
        end

        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                sv_p = $urandom_range(30, 100);
                pv_p = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(40, 100));
                mr_p = $urandom_range(0, 4) == 0 ? -1 : int'($urandom_range(20, 100));
                cfg_words = CW'($urandom_range(0, 5));
            end
            if ($urandom_range(199) == 0) enable = !enable;
            if (sq.size() < 2) sq.push_back($urandom);
            if (pq.size() < 4) pq.push_back({$urandom, $urandom} >> 24);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
